// File: rtl/box_physics_register.sv
// Vertical position/velocity register for the box: gravity, tap impulse, ceiling/floor
// clamping and a four-state flight FSM, all advanced once per game tick.
module box_physics_register #(
  parameter int Y_WIDTH      = 7,
  parameter int V_WIDTH      = 4,
  parameter int Y_INIT       = 60,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 120,
  parameter int GRAVITY      = 1,
  parameter int GRAVITY_DIV  = 2,
  parameter int FLAP_IMPULSE = 4,
  parameter int V_MAX_FALL   = 7
) (
  input  logic               i_game_tick_clock,
  input  logic               i_reset,
  input  logic               i_tap,
  input  logic               i_freeze,
  input  logic               i_restart,
  output logic [Y_WIDTH-1:0] o_y_coordinate,
  output logic [V_WIDTH-1:0] o_velocity,
  output logic [1:0]         o_flight_state,
  output logic               o_hit_floor,
  output logic               o_hit_ceiling
);

  if (!(Y_MIN < Y_INIT && Y_INIT < Y_MAX && Y_MAX <= (2 ** Y_WIDTH) - 1 &&
        FLAP_IMPULSE <= 2 ** (V_WIDTH - 1) && V_MAX_FALL <= (2 ** (V_WIDTH - 1)) - 1 &&
        GRAVITY_DIV >= 1 && V_WIDTH <= Y_WIDTH + 2)) begin : g_param_check
    $error("box_physics_register: illegal parameter combination");
  end

  localparam int SW = Y_WIDTH + 2;
  localparam int VW = V_WIDTH + 2;
  localparam int CW = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;

  localparam logic signed [SW-1:0] YMaxS     = SW'(Y_MAX);
  localparam logic signed [SW-1:0] YMinS     = SW'(Y_MIN);
  localparam logic signed [VW-1:0] VMaxFallS = VW'(V_MAX_FALL);
  localparam logic [Y_WIDTH-1:0]   YInit     = Y_WIDTH'(Y_INIT);
  localparam logic [Y_WIDTH-1:0]   YMax      = Y_WIDTH'(Y_MAX);
  localparam logic [Y_WIDTH-1:0]   YMin      = Y_WIDTH'(Y_MIN);
  localparam logic [V_WIDTH-1:0]   VFlap     = V_WIDTH'(-FLAP_IMPULSE);
  localparam logic [V_WIDTH-1:0]   VMaxFall  = V_WIDTH'(V_MAX_FALL);
  localparam logic [CW-1:0]        CntLast   = CW'(GRAVITY_DIV - 1);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StFlying   = 2'd1,
    StFalling  = 2'd2,
    StGrounded = 2'd3
  } flight_state_e;

  flight_state_e      r_state, w_state_d;
  logic [Y_WIDTH-1:0] r_y, w_y_d;
  logic [V_WIDTH-1:0] r_v, w_v_d;
  logic [CW-1:0]      r_cnt, w_cnt_d;
  logic               r_hit_floor, w_hit_floor_d;
  logic               r_hit_ceiling, w_hit_ceiling_d;

  logic signed [SW-1:0] w_sum;
  logic signed [VW-1:0] w_v_grav;

  // Wide signed arithmetic so neither the position sum nor the gravity add can wrap
  assign w_sum    = $signed({2'b00, r_y}) + SW'($signed(r_v));
  assign w_v_grav = VW'($signed(r_v)) + VW'(GRAVITY);

  always_comb begin
    w_state_d       = r_state;
    w_y_d           = r_y;
    w_v_d           = r_v;
    w_cnt_d         = r_cnt;
    w_hit_floor_d   = 1'b0;
    w_hit_ceiling_d = 1'b0;
    if (!i_freeze) begin
      unique case (r_state)
        StIdle: begin
          if (i_tap) begin
            w_v_d     = VFlap;
            w_cnt_d   = '0;
            w_state_d = StFlying;
          end
        end
        StFlying, StFalling: begin
          if (w_sum >= YMaxS) begin
            w_y_d         = YMax;
            w_v_d         = '0;
            w_state_d     = StGrounded;
            w_hit_floor_d = 1'b1;
          end else if (w_sum <= YMinS) begin
            w_y_d           = YMin;
            w_v_d           = '0;
            w_cnt_d         = '0;
            w_state_d       = StFalling;
            w_hit_ceiling_d = 1'b1;
          end else begin
            w_y_d = w_sum[Y_WIDTH-1:0];
            if (i_tap) begin
              w_v_d   = VFlap;
              w_cnt_d = '0;
            end else if (r_cnt == CntLast) begin
              w_v_d   = (w_v_grav > VMaxFallS) ? VMaxFall : w_v_grav[V_WIDTH-1:0];
              w_cnt_d = '0;
            end else begin
              w_cnt_d = r_cnt + 1'b1;
            end
            w_state_d = w_v_d[V_WIDTH-1] ? StFlying : StFalling;
          end
        end
        StGrounded: begin
          if (i_restart) begin
            w_y_d     = YInit;
            w_v_d     = '0;
            w_cnt_d   = '0;
            w_state_d = StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_game_tick_clock) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_y           <= YInit;
      r_v           <= '0;
      r_cnt         <= '0;
      r_hit_floor   <= 1'b0;
      r_hit_ceiling <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_y           <= w_y_d;
      r_v           <= w_v_d;
      r_cnt         <= w_cnt_d;
      r_hit_floor   <= w_hit_floor_d;
      r_hit_ceiling <= w_hit_ceiling_d;
    end
  end

  assign o_y_coordinate = r_y;
  assign o_velocity     = r_v;
  assign o_flight_state = r_state;
  assign o_hit_floor    = r_hit_floor;
  assign o_hit_ceiling  = r_hit_ceiling;

endmodule

// File: tb/tb_box_physics_register.sv
// Directed bench for box_physics_register with default parameters; expected values are
// hand-computed per edge.
module tb_box_physics_register;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0, i_tap = 1'b0, i_freeze = 1'b0, i_restart = 1'b0;
  logic [6:0] o_y_coordinate;
  logic [3:0] o_velocity;
  logic [1:0] o_flight_state;
  logic       o_hit_floor, o_hit_ceiling;

  int n_total = 0;
  int n_pass  = 0;

  box_physics_register dut (
    .i_game_tick_clock(clk),
    .i_reset          (i_reset),
    .i_tap            (i_tap),
    .i_freeze         (i_freeze),
    .i_restart        (i_restart),
    .o_y_coordinate   (o_y_coordinate),
    .o_velocity       (o_velocity),
    .o_flight_state   (o_flight_state),
    .o_hit_floor      (o_hit_floor),
    .o_hit_ceiling    (o_hit_ceiling)
  );

  always #5 clk = ~clk;

  task automatic step(input logic tap, input logic frz, input logic rst_req,
                      input logic rst);
    i_tap = tap; i_freeze = frz; i_restart = rst_req; i_reset = rst;
    @(posedge clk);
    #1;
    i_tap = 1'b0; i_freeze = 1'b0; i_restart = 1'b0; i_reset = 1'b0;
  endtask

  task automatic check(input string tag, input int ey, input int ev, input int est,
                       input logic ehf, input logic ehc);
    logic [14:0] obs, exp;
    obs = {o_y_coordinate, o_velocity, o_flight_state, o_hit_floor, o_hit_ceiling};
    exp = {7'(ey), 4'(ev), 2'(est), ehf, ehc};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got y=%0d v=%0d st=%0d hf=%b hc=%b, want y=%0d v=%0d st=%0d hf=%b hc=%b",
                tag, o_y_coordinate, $signed(o_velocity), o_flight_state, o_hit_floor,
                o_hit_ceiling, ey, ev, est, ehf, ehc);
  endtask

  int t2_y[8] = '{56, 52, 49, 46, 44, 42, 41, 40};
  int t2_v[8] = '{-4, -3, -3, -2, -2, -1, -1, 0};
  int t3_y[19] = '{40, 40, 41, 42, 44, 46, 49, 52, 56, 60, 65, 70, 76, 82, 89, 96, 103, 110, 117};
  int t3_v[19] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 7, 7, 7, 7};
  int t4_lead_y[5] = '{56, 52, 49, 46, 44};
  int t4_lead_v[5] = '{-4, -3, -3, -2, -2};

  initial begin
    // Reset and idle hold
    step(0, 0, 0, 1);
    check("reset", 60, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      check("idle_hold", 60, 0, 0, 0, 0);
    end

    // Tap from IDLE, then coast up to apex
    step(1, 0, 0, 0);
    check("idle_tap", 60, -4, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0);
      check("coast", t2_y[i], t2_v[i], (i == 7) ? 2 : 1, 0, 0);
    end

    // Free fall to the floor
    for (int i = 0; i < 19; i++) begin
      step(0, 0, 0, 0);
      check("fall", t3_y[i], t3_v[i], 2, 0, 0);
    end
    step(0, 0, 0, 0);
    check("land", 120, 0, 3, 1, 0);
    step(1, 0, 0, 0);
    check("grounded_tap1", 120, 0, 3, 0, 0);
    step(1, 0, 0, 0);
    check("grounded_tap2", 120, 0, 3, 0, 0);
    step(0, 0, 1, 0);
    check("restart", 60, 0, 0, 0, 0);

    // Climb with repeated taps into the ceiling
    step(1, 0, 0, 0);
    check("t4_tap", 60, -4, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      check("t4_lead", t4_lead_y[i], t4_lead_v[i], 1, 0, 0);
    end
    for (int y = 42; y >= 2; y -= 4) begin
      step(1, 0, 0, 0);
      check("climb", y, -4, 1, 0, 0);
    end
    step(1, 0, 0, 0);
    check("ceiling", 0, 0, 2, 0, 1);
    step(0, 1, 0, 0);
    check("freeze_clears_pulse", 0, 0, 2, 0, 0);

    // Freeze mid-flight with taps and restart discarded
    step(0, 0, 0, 1);
    check("reset2", 60, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("t5_tap", 60, -4, 1, 0, 0);
    step(0, 0, 0, 0);
    check("t5_pre", 56, -4, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, (i == 2), 0);
      check("frozen", 56, -4, 1, 0, 0);
    end
    step(0, 0, 0, 0);
    check("unfreeze", 52, -3, 1, 0, 0);
    step(0, 0, 1, 0);
    check("restart_in_flight", 49, -3, 1, 0, 0);

    // Reset beats everything
    step(1, 1, 1, 1);
    check("reset_mid_flight", 60, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
